mux_lut_fold_scheduler: RTL and testbench

Time-shared controller for a single 2-input mux-tree logic cell: a 4:1 mux whose data inputs are a 4-bit truth table, which implements any 2-input gate (XOR = 4'b0110, AND = 4'b1000, OR = 4'b1110). Up to N_REQ requesters each submit a WIDTH-bit word plus a truth table. A round-robin arbiter grants one request at a time. The block then folds the word bit-serially through the cell, LSB first, one bit per cycle, and returns a 1-bit result with the requester ID over a valid/ready handshake. It sits between multiple combinational-exercise clients and one shared gate cell.

---
 rtl/mux_lut_fold_scheduler.sv | 176 +++++++++++++++++
 tb/tb_mux_lut_fold_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_lut_fold_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_lut_fold_scheduler: round-robin time-sharing of one 2-input LUT cell,   |
// | folding each granted word LSB-first and returning a 1-bit tagged result.    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mux_lut_fold_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_data,
  input  logic [N_REQ*4-1:0]         req_lut,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic                       res_data,
  output logic [$clog2(N_REQ)-1:0]   res_id,
  output logic                       busy
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int SUM_W = ID_W + 1;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic               acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [3:0]         lut_q, lut_d;
  logic               res_valid_q, res_valid_d;
  logic               res_data_q, res_data_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;

  logic [N_REQ-1:0]   rot_valid;
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [SUM_W-1:0]   sum;
  logic [WIDTH-1:0]   sel_word;
  logic [3:0]         sel_lut;
  logic               fold_bit;
  logic               acc_next;

  // Rotate so that position 0 is the requester at ptr; first set bit wins.
  always_comb begin
    rot_valid   = N_REQ'({req_valid, req_valid} >> ptr_q);
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_found && rot_valid[k]) begin
        grant_found = 1'b1;
        sum = {1'b0, ptr_q} + SUM_W'(k);
        if (sum >= SUM_W'(N_REQ)) begin
          sum = sum - SUM_W'(N_REQ);
        end
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !rst && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_word = '0;
    sel_lut  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ID_W'(k) == grant_idx) begin
        sel_word = req_data[k*WIDTH +: WIDTH];
        sel_lut  = req_lut[k*4 +: 4];
      end
    end
  end

  assign fold_bit = |(word_q & (WIDTH'(1) << cnt_q));
  assign acc_next = lut_q[{acc_q, fold_bit}];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    word_d      = word_q;
    lut_d       = lut_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          word_d = sel_word;
          lut_d  = sel_lut;
          acc_d  = sel_word[0];
          cnt_d  = CNT_W'(1);
          id_d   = grant_idx;
          ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          if (WIDTH > 1) begin
            state_d = FOLD;
          end else begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_data_d  = sel_word[0];
            res_id_d    = grant_idx;
          end
        end
      end
      FOLD: begin
        acc_d = acc_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == C_LAST) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_data_d  = acc_next;
          res_id_d    = id_q;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      acc_q       <= 1'b0;
      cnt_q       <= '0;
      id_q        <= '0;
      word_q      <= '0;
      lut_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= 1'b0;
      res_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      word_q      <= word_d;
      lut_q       <= lut_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mux_lut_fold_scheduler.sv
`default_nettype none
// Testbench for mux_lut_fold_scheduler: vector table, corner-case sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mux_lut_fold_scheduler;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_data;
  logic [N*4-1:0] req_lut;
  logic           res_valid;
  logic           res_ready;
  logic           res_data;
  logic [1:0]     res_id;
  logic           busy;

  int checks = 0;
  int failures = 0;
  int g_id[$];
  int g_cyc[$];

  mux_lut_fold_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_lut(req_lut), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         r;
    logic [7:0] d;
    logic [3:0] l;
    logic       exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference fold: acc starts at bit 0, each further bit selects lut[2*acc+bit].
  function automatic logic fold(input logic [7:0] d, input logic [3:0] l);
    int a;
    a = int'(d[0]);
    for (int i = 1; i < W; i++) a = int'(l[a * 2 + int'(d[i])]);
    return a[0];
  endfunction

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!res_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_txn(input int r, input logic [7:0] d, input logic [3:0] l,
                         input logic exp, input bit scramble);
    int lat;
    req_data[r*8 +: 8] = d;
    req_lut[r*4 +: 4]  = l;
    req_valid = 4'(1 << r);
    res_ready = 1'b1;
    #1;
    check("txn_ready", 32'(req_ready), 32'(1 << r));
    step();
    req_valid = '0;
    if (scramble) begin
      req_data = $urandom;
      req_lut  = 16'($urandom);
    end
    wait_valid(lat);
    check("txn_latency", 32'(lat), 32'(W - 1));
    check("txn_data", 32'(res_data), 32'(exp));
    check("txn_id", 32'(res_id), 32'(r));
    step();
    check("txn_idle_after", 32'({busy, res_valid}), 32'd0);
  endtask

  task automatic collect(input int n);
    int c = 0;
    g_id.delete();
    g_cyc.delete();
    while (g_id.size() < n && c < 300) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          g_id.push_back(i);
          g_cyc.push_back(c);
        end
      end
      step();
      c++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (busy && c < 40) begin
      step();
      c++;
    end
    check("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t vecs[6];
    int   lat;
    int   ptr_m;
    logic exp_b;

    vecs[0] = '{0, 8'h07, 4'b0110, 1'b1};
    vecs[1] = '{0, 8'hB1, 4'b0110, 1'b0};
    vecs[2] = '{1, 8'hFF, 4'b1000, 1'b1};
    vecs[3] = '{2, 8'hFE, 4'b1000, 1'b0};
    vecs[4] = '{3, 8'h00, 4'b1110, 1'b0};
    vecs[5] = '{0, 8'h80, 4'b1110, 1'b1};

    rst = 1'b1;
    req_valid = '1;
    req_data = '0;
    req_lut = '0;
    res_ready = 1'b0;
    step();
    step();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_outputs", 32'({res_valid, res_data, res_id, busy}), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ptr_grant0", 32'(req_ready), 32'd1);
    req_valid = '0;
    step();

    // Vector table
    foreach (vecs[i]) run_txn(vecs[i].r, vecs[i].d, vecs[i].l, vecs[i].exp, 1'b0);

    // Captured inputs: requester changes data/lut right after accept
    run_txn(1, 8'h07, 4'b0110, 1'b1, 1'b1);
    run_txn(2, 8'hFE, 4'b1000, 1'b0, 1'b1);

    // Round robin with all requesters valid
    do_reset();
    req_data = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
    req_lut  = {4'b1000, 4'b1000, 4'b1000, 4'b1000};
    res_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    collect(5);
    check("rr_count", 32'(g_id.size()), 32'd5);
    if (g_id.size() == 5) begin
      for (int i = 0; i < 5; i++) check("rr_order", 32'(g_id[i]), 32'(i % 4));
      for (int i = 1; i < 5; i++) check("rr_interval", 32'(g_cyc[i] - g_cyc[i-1]), 32'(W + 1));
    end
    req_valid = 4'b1010;
    #1;
    collect(3);
    check("rr2_count", 32'(g_id.size()), 32'd3);
    if (g_id.size() == 3) begin
      check("rr2_0", 32'(g_id[0]), 32'd1);
      check("rr2_1", 32'(g_id[1]), 32'd3);
      check("rr2_2", 32'(g_id[2]), 32'd1);
    end
    req_valid = '0;
    wait_idle();

    // Backpressure in DONE
    req_data[2*8 +: 8] = 8'h07;
    req_lut[2*4 +: 4]  = 4'b0110;
    req_valid = 4'b0100;
    res_ready = 1'b0;
    step();
    req_valid = 4'b1111;
    wait_valid(lat);
    check("bp_latency", 32'(lat), 32'(W - 1));
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 32'({res_valid, res_data, res_id, busy}), 32'({1'b1, 1'b1, 2'd2, 1'b1}));
      check("bp_no_ready", 32'(req_ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    check("bp_valid_before_edge", 32'(res_valid), 32'd1);
    step();
    req_valid = '0;
    check("bp_handshake", 32'({res_valid, busy}), 32'd0);
    step();

    // Reset mid-FOLD: aborted word from requester 1 leaves no result
    req_data[1*8 +: 8] = 8'hFF;
    req_lut[1*4 +: 4]  = 4'b1000;
    req_valid = 4'b0010;
    step();
    req_valid = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_state", 32'({busy, res_valid}), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 12; i++) begin
        if (res_valid) seen++;
        step();
      end
      check("abort_no_result", 32'(seen), 32'd0);
    end
    req_valid = 4'b1010;
    #1;
    check("abort_ptr_restart", 32'(req_ready), 32'b0010);
    req_valid = '0;
    run_txn(2, 8'hB1, 4'b0110, 1'b0, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    ptr_m = 0;
    for (int t = 0; t < 40; t++) begin
      logic [3:0] mask;
      int g;
      int c;
      logic [7:0] d;
      logic [3:0] l;
      mask = 4'($urandom_range(1, 15));
      req_data = $urandom;
      req_lut  = 16'($urandom);
      req_valid = mask;
      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && mask[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      end
      d = req_data[g*8 +: 8];
      l = req_lut[g*4 +: 4];
      exp_b = fold(d, l);
      res_ready = 1'($urandom);
      #1;
      check("rnd_grant", 32'(req_ready), 32'(1 << g));
      step();
      req_valid = '0;
      req_data = $urandom;
      req_lut  = 16'($urandom);
      wait_valid(lat);
      check("rnd_latency", 32'(lat), 32'(W - 1));
      c = 0;
      res_ready = 1'($urandom);
      while (!res_ready && c < 20) begin
        check("rnd_hold", 32'({res_valid, res_data, res_id}), 32'({1'b1, exp_b, 2'(g)}));
        step();
        res_ready = 1'($urandom);
        c++;
      end
      res_ready = 1'b1;
      #1;
      check("rnd_result", 32'({res_valid, res_data, res_id}), 32'({1'b1, exp_b, 2'(g)}));
      step();
      check("rnd_idle", 32'(busy), 32'd0);
      ptr_m = (g + 1) % N;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
